// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle MIPS datapath with a shared ALU and a shared memory.
// It steps each instruction through its states, stalls on mem_ready_i, and counts retirements.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       instr_op_i,
  input  logic             mem_ready_i,
  output logic             PCWrite_o,
  output logic             PCWriteCond_o,
  output logic [1:0]       PCSrc_o,
  output logic             IorD_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             IRWrite_o,
  output logic             RegDst_o,
  output logic             RegWrite_o,
  output logic             MemtoReg_o,
  output logic             ALUSrcA_o,
  output logic [1:0]       ALUSrcB_o,
  output logic [2:0]       ALU_op_o,
  output logic             instr_done_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] retired_cnt_o
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_RWB    = 4'd8;
  localparam logic [3:0] S_IEXEC  = 4'd9;
  localparam logic [3:0] S_IWB    = 4'd10;
  localparam logic [3:0] S_BRANCH = 4'd11;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_SLT   = 3'b010;
  localparam logic [2:0] ALU_FUNCT = 3'b100;

  logic [3:0]       state_q;
  logic [3:0]       state_next;
  logic [5:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_R, OP_BEQ, OP_ADDI, OP_SLTI, OP_LW, OP_SW: op_legal = 1'b1;
      default:                                      op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] decode_target(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:     decode_target = S_MEMADR;
      OP_R:             decode_target = S_EXEC;
      OP_ADDI, OP_SLTI: decode_target = S_IEXEC;
      OP_BEQ:           decode_target = S_BRANCH;
      default:          decode_target = S_FETCH;
    endcase
  endfunction

  always_comb begin
    state_next = state_q;
    case (state_q)
      S_IDLE:   state_next = S_FETCH;
      S_FETCH:  if (mem_ready_i) state_next = S_DECODE;
      S_DECODE: state_next = decode_target(instr_op_i);
      S_MEMADR: state_next = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready_i) state_next = S_MEMWB;
      S_MEMWB:  state_next = S_FETCH;
      S_MEMWR:  if (mem_ready_i) state_next = S_FETCH;
      S_EXEC:   state_next = S_RWB;
      S_RWB:    state_next = S_FETCH;
      S_IEXEC:  state_next = S_IWB;
      S_IWB:    state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      default:  state_next = S_IDLE;
    endcase
  end

  // A store retires in the cycle its write completes; every other retiring state is unconditional.
  always_comb begin
    case (state_q)
      S_MEMWB, S_RWB, S_IWB, S_BRANCH: retire = 1'b1;
      S_MEMWR:                         retire = mem_ready_i;
      default:                         retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_next;
      if (state_q == S_DECODE) op_q <= instr_op_i;
      if (retire) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    PCSrc_o       = 2'b00;
    IorD_o        = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    IRWrite_o     = 1'b0;
    RegDst_o      = 1'b0;
    RegWrite_o    = 1'b0;
    MemtoReg_o    = 1'b0;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = 2'b00;
    ALU_op_o      = ALU_ADD;
    illegal_o     = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead_o = 1'b1;
        ALUSrcB_o = 2'b01;
        IRWrite_o = mem_ready_i;
        PCWrite_o = mem_ready_i;
      end
      // op_q is not loaded yet, so the illegal check looks at the live IR opcode.
      S_DECODE: begin
        ALUSrcB_o = 2'b11;
        illegal_o = ~op_legal(instr_op_i);
      end
      S_MEMADR: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
      end
      S_MEMRD: begin
        MemRead_o = 1'b1;
        IorD_o    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite_o = 1'b1;
        MemtoReg_o = 1'b1;
      end
      S_MEMWR: begin
        MemWrite_o = 1'b1;
        IorD_o     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA_o = 1'b1;
        ALU_op_o  = ALU_FUNCT;
      end
      S_RWB: begin
        RegWrite_o = 1'b1;
        RegDst_o   = 1'b1;
      end
      S_IEXEC: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
        ALU_op_o  = (op_q == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_IWB: begin
        RegWrite_o = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA_o     = 1'b1;
        ALU_op_o      = ALU_SUB;
        PCWriteCond_o = 1'b1;
        PCSrc_o       = 2'b01;
      end
      default: begin
      end
    endcase
  end

  assign instr_done_o  = retire;
  assign retired_cnt_o = cnt_q;

endmodule
